wb_csr_responder: RTL and testbench
===================================

Name: wb_csr_responder

Overview:
- Wishbone classic slave (responder) for the Caravel-style user bus. Exposes p_num_regs 32-bit control/status registers to the management SoC (the initiator).
- Registers are readable and writable from the bus, with byte-lane selects.
- Each register also has a hardware-side write port so user logic can post status.
- Sits between the Wishbone wrapper and the user datapath; the register contents drive datapath configuration.

Parameters:
- p_num_regs, 4, number of 32-bit registers; legal range 1..16.
- p_base_addr, 32'h3000_0000, byte address of register 0; register i is at p_base_addr + 4*i.
- p_reset_value, 32'h0000_0000, value loaded into every register on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wbs_cyc_i  in  1  bus cycle active.
- wbs_stb_i  in  1  strobe; request valid when cyc & stb.
- wbs_we_i  in  1  1 = write, 0 = read.
- wbs_sel_i  in  4  byte-lane enables; bit k covers dat[8k+7:8k].
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  registered single-cycle acknowledge.
- wbs_dat_o  out  32  registered read data, valid while ack is high.
- hw_wr_en  in  p_num_regs  per-register hardware write enable.
- hw_wr_data  in  32*p_num_regs  hardware write data; register i uses slice [32i+31:32i].
- reg_q  out  32*p_num_regs  current register contents, same slicing as hw_wr_data.
- bus_wr_pulse  out  p_num_regs  one-cycle pulse marking the cycle a bus write to register i commits.

Behaviour:
- Reset values: wbs_ack_o=0, wbs_dat_o=0, bus_wr_pulse=0, all registers=p_reset_value. Reset has priority over every other event.
- FSM states:
  - IDLE: on cyc & stb & !ack, accept the request and go to ACK.
  - ACK: wbs_ack_o=1 for exactly one cycle, then return to IDLE unconditionally.
- Ack timing:
  - ack asserts on the cycle after acceptance; latency is 1 cycle.
  - ack is never high on two consecutive cycles.
  - A request still asserted in the ACK cycle is not re-accepted.
  - A new request may be accepted the cycle after ack, giving a throughput of one transfer per 2 cycles.
- Decode:
  - Hit when adr[1:0]==0 and (adr - p_base_addr)>>2 < p_num_regs. Use a 32-bit unsigned subtract; adr below base is a miss.
  - Misaligned or out-of-range requests are still acked. Reads return 32'h0; writes are dropped with no pulse. No err/rty.
- Writes:
  - At the acceptance edge, selected bytes of the hit register take dat_i; unselected bytes hold.
  - bus_wr_pulse[i]=1 during the ACK cycle; 0 otherwise.
  - sel=0 still acks and still pulses, but the register value is unchanged.
- Reads:
  - wbs_dat_o captures the register value present at the acceptance edge, i.e. pre-update, ignoring any same-edge hw write.
  - wbs_dat_o holds its value after ack drops until the next read is accepted.
  - Write transfers leave wbs_dat_o unchanged.
- Hardware writes: when hw_wr_en[i]=1, register i takes the full 32-bit slice at the edge.
- Collision: a bus write and a hw write to the same register on the same edge.
  - Bus-selected bytes take the bus data.
  - Unselected bytes take the hw data.
- reg_q is driven directly from the register flops, so updates are visible the cycle after the write edge.
- cyc deasserted while in ACK: ack still completes; the bus ignores it.
- Reset mid-transfer: a reset during the ACK cycle forces ack=0 the next cycle and returns to IDLE. The pending write, if already committed, is overwritten by the reset value.

Test Plan:
- Reset, then read every register -> each read acks 1 cycle after stb with dat_o=p_reset_value; reg_q all zero.
- Write 32'hDEADBEEF, sel=4'hF, to base+4; read it back -> reg_q[63:32]=DEADBEEF; bus_wr_pulse=4'b0010 for 1 cycle; read returns DEADBEEF.
- Write 32'h11223344 with sel=4'b0101 to base over 32'hAAAAAAAA -> register becomes 32'hAA22AA44.
- Same-edge bus write 32'h000000FF (sel=4'b0001) and hw write 32'h12345678 to register 2 -> result 32'h123456FF.
- Hold stb continuously for 6 cycles -> ack pattern 0,1,0,1,0,1; ack never high on consecutive cycles.
- Read base+4*p_num_regs and base+2 -> ack=1, dat_o=0, no register changes; then assert reset during an ACK cycle -> ack=0 next cycle, all registers=p_reset_value.

Source files
------------

// File: rtl/wb_csr_responder.sv
// rtl/wb_csr_responder.sv - Wishbone classic CSR responder with byte lanes and hardware write ports
module wb_csr_responder #(
    parameter int          p_num_regs    = 4,
    parameter logic [31:0] p_base_addr   = 32'h3000_0000,
    parameter logic [31:0] p_reset_value = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wbs_cyc_i,
    input  logic                       wbs_stb_i,
    input  logic                       wbs_we_i,
    input  logic [3:0]                 wbs_sel_i,
    input  logic [31:0]                wbs_adr_i,
    input  logic [31:0]                wbs_dat_i,
    output logic                       wbs_ack_o,
    output logic [31:0]                wbs_dat_o,
    input  logic [p_num_regs-1:0]      hw_wr_en,
    input  logic [32*p_num_regs-1:0]   hw_wr_data,
    output logic [32*p_num_regs-1:0]   reg_q,
    output logic [p_num_regs-1:0]      bus_wr_pulse
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t                       r_state;
    state_t                       w_state_next;
    logic                         w_accept;
    logic                         w_bus_wr;
    logic                         w_aligned;
    logic [31:0]                  w_off;
    logic [29:0]                  w_word;
    logic [31:0]                  w_bmask;
    logic [31:0]                  w_rd_data;
    logic [p_num_regs-1:0]        w_hit_vec;
    logic [p_num_regs-1:0][31:0]  r_regs;
    logic [p_num_regs-1:0][31:0]  w_regs_next;
    logic [p_num_regs-1:0]        r_pulse;
    logic [31:0]                  r_dat;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ACK always falls back to IDLE, so a held request is accepted every other cycle
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_ACK;
                end
            end
            ST_ACK:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign wbs_ack_o = (r_state == ST_ACK);
    assign w_bus_wr  = w_accept && wbs_we_i;

    // Unsigned offset wraps for addresses below base, turning them into misses
    assign w_off     = wbs_adr_i - p_base_addr;
    assign w_word    = 30'(w_off >> 2);
    assign w_aligned = (wbs_adr_i[1:0] == 2'b00);
    assign w_bmask   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                        {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

    always_comb begin
        logic [31:0] v_base;
        v_base      = '0;
        w_hit_vec   = '0;
        w_rd_data   = '0;
        w_regs_next = r_regs;
        for (int i = 0; i < p_num_regs; i++) begin
            w_hit_vec[i] = w_aligned && (w_word == 30'(i));
            // hw write supplies the full word; bus-selected bytes override it
            v_base = hw_wr_en[i] ? hw_wr_data[32*i +: 32] : r_regs[i];
            if (w_bus_wr && w_hit_vec[i]) begin
                w_regs_next[i] = (wbs_dat_i & w_bmask) | (v_base & ~w_bmask);
            end else begin
                w_regs_next[i] = v_base;
            end
            if (w_hit_vec[i]) begin
                w_rd_data = r_regs[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_regs  <= {p_num_regs{p_reset_value}};
            r_pulse <= '0;
            r_dat   <= '0;
        end else begin
            r_regs  <= w_regs_next;
            r_pulse <= w_bus_wr ? w_hit_vec : '0;
            if (w_accept && !wbs_we_i) begin
                r_dat <= w_rd_data;
            end
        end
    end

    assign reg_q        = r_regs;
    assign bus_wr_pulse = r_pulse;
    assign wbs_dat_o    = r_dat;

endmodule

// File: tb/tb_wb_csr_responder.sv
// tb/tb_wb_csr_responder.sv - self-checking bench for wb_csr_responder against a word-array model
module tb_wb_csr_responder;

    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic           clk = 1'b0;
    logic           reset;
    logic           cyc, stb, we;
    logic [3:0]     sel;
    logic [31:0]    adr, dat_i;
    logic           ack;
    logic [31:0]    dat_o;
    logic [N-1:0]   hw_en;
    logic [32*N-1:0] hw_data;
    logic [32*N-1:0] reg_q;
    logic [N-1:0]   pulse;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] mdl [N];
    logic [31:0] m_dat;

    wb_csr_responder #(
        .p_num_regs   (N),
        .p_base_addr  (BASE),
        .p_reset_value(32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (dat_i),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (dat_o),
        .hw_wr_en    (hw_en),
        .hw_wr_data  (hw_data),
        .reg_q       (reg_q),
        .bus_wr_pulse(pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [127:0] model_q();
        logic [127:0] q;
        q = '0;
        for (int k = 0; k < N; k++) q[32*k +: 32] = mdl[k];
        return q;
    endfunction

    function automatic bit m_hit(input logic [31:0] a, output int idx);
        logic [31:0] off;
        off = a - BASE;
        idx = int'(off / 4);
        return (off % 4 == 0) && (off / 4 < N);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) mdl[k] = 32'h0;
        m_dat = 32'h0;
    endtask

    // one complete transfer: drive, check the ACK cycle, check the idle cycle after
    task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [N-1:0] he, input logic [32*N-1:0] hd);
        int          idx;
        bit          hit;
        logic [31:0] exp_rd;
        logic [N-1:0] exp_pulse;
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = a; dat_i = d; sel = s; hw_en = he; hw_data = hd;
        hit    = m_hit(a, idx);
        exp_rd = hit ? mdl[idx] : 32'h0;
        for (int k = 0; k < N; k++) if (he[k]) mdl[k] = hd[32*k +: 32];
        if (w && hit)
            for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
        exp_pulse = (w && hit) ? N'(1 << idx) : '0;
        if (!w) m_dat = exp_rd;
        @(negedge clk);
        chk("ack_hi", 128'(ack), 128'(1'b1));
        chk("pulse", 128'(pulse), 128'(exp_pulse));
        chk("dat_o", 128'(dat_o), 128'(m_dat));
        chk("reg_q", reg_q, model_q());
        cyc = 0; stb = 0; we = 0; hw_en = '0;
        @(negedge clk);
        chk("ack_lo", 128'(ack), 128'(1'b0));
        chk("pulse_lo", 128'(pulse), 128'(0));
    endtask

    initial begin
        int          r;
        int          ri;
        logic [31:0] a;
        reset = 1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat_i = 0;
        hw_en = '0; hw_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_ack", 128'(ack), 128'(1'b0));
        chk("rst_dat", 128'(dat_o), 128'(0));
        chk("rst_pulse", 128'(pulse), 128'(0));
        chk("rst_regq", reg_q, 128'(0));
        reset = 0;

        for (int i = 0; i < N; i++) xfer(1'b0, BASE + 32'(4*i), 32'h0, 4'hF, '0, '0);

        xfer(1'b1, BASE + 4, 32'hDEADBEEF, 4'hF, '0, '0);
        chk("deadbeef_q", 128'(reg_q[63:32]), 128'(32'hDEADBEEF));
        xfer(1'b0, BASE + 4, 32'h0, 4'hF, '0, '0);
        chk("deadbeef_rd", 128'(dat_o), 128'(32'hDEADBEEF));

        xfer(1'b1, BASE, 32'hAAAAAAAA, 4'hF, '0, '0);
        xfer(1'b1, BASE, 32'h11223344, 4'b0101, '0, '0);
        chk("byte_lanes", 128'(reg_q[31:0]), 128'(32'hAA22AA44));

        xfer(1'b1, BASE + 8, 32'h000000FF, 4'b0001, 4'b0100, {32'h0, 32'h12345678, 64'h0});
        chk("collision", 128'(reg_q[95:64]), 128'(32'h123456FF));

        xfer(1'b1, BASE + 12, 32'h55555555, 4'h0, '0, '0);
        chk("sel_zero", 128'(reg_q[127:96]), 128'(0));

        // back-to-back request held for six cycles
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = BASE + 4; sel = 4'hF;
        m_dat = mdl[1];
        for (int c = 0; c < 6; c++) begin
            chk("hold_ack", 128'(ack), 128'(c % 2));
            @(negedge clk);
        end
        cyc = 0; stb = 0;
        chk("hold_dat", 128'(dat_o), 128'(m_dat));
        @(negedge clk);

        xfer(1'b0, BASE + 32'(4*N), 32'h0, 4'hF, '0, '0);
        chk("oor_rd", 128'(dat_o), 128'(0));
        xfer(1'b1, BASE + 2, 32'hFFFFFFFF, 4'hF, '0, '0);
        xfer(1'b0, BASE + 2, 32'h0, 4'hF, '0, '0);
        chk("mis_rd", 128'(dat_o), 128'(0));

        for (int it = 0; it < 60; it++) begin
            r  = int'($urandom_range(0, 9));
            ri = int'($urandom_range(0, N-1));
            case (r)
                6:       a = BASE + 32'(4*N);
                7:       a = BASE + 32'(4*ri) + 32'($urandom_range(1, 3));
                8:       a = BASE - 4;
                9:       a = $urandom;
                default: a = BASE + 32'(4*ri);
            endcase
            xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 15)) : '0,
                 {$urandom, $urandom, $urandom, $urandom});
        end

        // reset landing in the ACK cycle of a committed write
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; adr = BASE + 8; dat_i = 32'hCAFEF00D; sel = 4'hF;
        @(negedge clk);
        chk("pre_rst_ack", 128'(ack), 128'(1'b1));
        cyc = 0; stb = 0; we = 0;
        reset = 1;
        @(negedge clk);
        model_reset();
        chk("mid_rst_ack", 128'(ack), 128'(1'b0));
        chk("mid_rst_regq", reg_q, model_q());
        chk("mid_rst_pulse", 128'(pulse), 128'(0));
        chk("mid_rst_dat", 128'(dat_o), 128'(0));
        reset = 0;
        xfer(1'b0, BASE + 8, 32'h0, 4'hF, '0, '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
